// File: rtl/sfifo_rr_ctrl.sv
// Round-robin write arbiter and valid/ready read sequencer in front of a
// 16x8 synchronous FIFO, with a shadow occupancy count and consistency flag.
module sfifo_rr_ctrl #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              fifo_write,
    output logic [7:0]        fifo_iData,
    output logic              fifo_read,
    input  logic [7:0]        fifo_oData,
    input  logic              fifo_empty,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [4:0]        level,
    output logic              err
);

    localparam int PW = $clog2(NREQ);
    localparam logic [4:0] FULL = 5'(DEPTH);

    logic [PW-1:0] rr_ptr;
    logic          rd_pend;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    // Search starts just after the last winner; k == NREQ wraps back to rr_ptr.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = rr_ptr + PW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (!RSTn || level == FULL)
            found = 1'b0;
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++)
            gnt[i] = found && (gidx == PW'(i));
    end

    assign fifo_write = found;
    assign fifo_iData = found ? req_data[gidx*8 +: 8] : 8'h00;
    assign fifo_read  = RSTn && (level != 5'd0) && !rd_pend && (!out_valid || out_ready);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            level     <= '0;
            rr_ptr    <= PW'(NREQ - 1);
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            err       <= 1'b0;
        end else begin
            level   <= level + 5'(fifo_write) - 5'(fifo_read);
            rd_pend <= fifo_read;
            if (fifo_write)
                rr_ptr <= gidx;
            // A read is only issued when the output register is free or draining.
            if (rd_pend) begin
                out_data  <= fifo_oData;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (!rd_pend && ((level == 5'd0) != fifo_empty))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sfifo_rr_ctrl.sv
// Bench for sfifo_rr_ctrl: behavioural FIFO, vector tables for arbitration,
// and an in-order data scoreboard on the output stream.
module tb_sfifo_rr_ctrl;

    logic        CLK, RSTn;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_write, fifo_read, fifo_empty;
    logic [7:0]  fifo_iData, fifo_oData;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [4:0]  level;
    logic        err;

    int ntests = 0;
    int nfail  = 0;
    int n_out  = 0;
    logic [7:0] sbq[$];

    sfifo_rr_ctrl #(.NREQ(4), .DEPTH(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_write(fifo_write), .fifo_iData(fifo_iData), .fifo_read(fifo_read),
        .fifo_oData(fifo_oData), .fifo_empty(fifo_empty), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .level(level), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural 16x8 FIFO: registered read data, empty from its own count.
    logic [7:0] fmem [16];
    logic [3:0] wp, rp;
    int         fcnt;
    logic       force_empty;
    assign fifo_empty = force_empty || (fcnt == 0);

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp <= '0; rp <= '0; fcnt <= 0; fifo_oData <= 8'h00;
        end else begin
            if (fifo_write) begin fmem[wp] <= fifo_iData; wp <= wp + 4'd1; end
            if (fifo_read)  begin fifo_oData <= fmem[rp]; rp <= rp + 4'd1; end
            fcnt <= fcnt + int'(fifo_write) - int'(fifo_read);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: order/hold checks, then record any byte accepted this cycle.
    logic       hold_chk = 1'b0;
    logic [7:0] held;
    always @(negedge CLK) begin
        if (RSTn) begin
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            hold_chk = out_valid && !out_ready;
            held     = out_data;
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL out_unexpected: got %0h expected none", out_data);
                end else begin
                    chk("out_order", out_data, sbq.pop_front());
                end
            end
            for (int i = 0; i < 4; i++)
                if (gnt[i]) sbq.push_back(req_data[8*i +: 8]);
        end else begin
            hold_chk = 1'b0;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  gnt;
        logic        rd;
        logic [4:0]  lvl;
        logic        ov;
        logic [7:0]  od;
    } vec_t;

    vec_t fv[7];
    vec_t sv[5];

    task automatic cyc(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        req = v.req; req_data = v.data; out_ready = v.rdy;
        @(negedge CLK);
        chk({tag, "_gnt"}, gnt, v.gnt);
        chk({tag, "_write"}, fifo_write, |v.gnt);
        chk({tag, "_read"}, fifo_read, v.rd);
        chk({tag, "_level"}, level, v.lvl);
        chk({tag, "_ovalid"}, out_valid, v.ov);
        chk({tag, "_odata"}, out_data, v.od);
        @(posedge CLK); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_write"}, fifo_write, 0);
        chk({tag, "_idata"}, fifo_iData, 0);
        chk({tag, "_read"}, fifo_read, 0);
        chk({tag, "_ovalid"}, out_valid, 0);
        chk({tag, "_odata"}, out_data, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Hold a single request until granted, bounded.
    task automatic push(input int idx, input logic [7:0] b);
        int t = 0;
        req = 4'(1 << idx);
        req_data = 32'(b) << (8 * idx);
        @(negedge CLK);
        while (!gnt[idx] && t < 50) begin @(negedge CLK); t++; end
        if (!gnt[idx]) chk("push_timeout", gnt, 4'(1 << idx));
        @(posedge CLK); #1;
        req = 4'h0;
    endtask

    initial begin
        int ngr, nbefore, t;
        logic seen;

        // Fairness from reset: rr_ptr=3 so requester 0 leads; consumer stalled.
        fv[0] = '{4'hF, 32'h13121110, 1'b0, 4'b0001, 1'b0, 5'd0, 1'b0, 8'h00};
        fv[1] = '{4'hF, 32'h13121110, 1'b0, 4'b0010, 1'b1, 5'd1, 1'b0, 8'h00};
        fv[2] = '{4'hF, 32'h13121110, 1'b0, 4'b0100, 1'b0, 5'd1, 1'b0, 8'h00};
        fv[3] = '{4'hF, 32'h13121110, 1'b0, 4'b1000, 1'b0, 5'd2, 1'b1, 8'h10};
        fv[4] = '{4'hF, 32'h13121110, 1'b0, 4'b0001, 1'b0, 5'd3, 1'b1, 8'h10};
        fv[5] = '{4'hF, 32'h13121110, 1'b0, 4'b0010, 1'b0, 5'd4, 1'b1, 8'h10};
        fv[6] = '{4'h0, 32'h13121110, 1'b0, 4'b0000, 1'b0, 5'd5, 1'b1, 8'h10};
        // Single producer, idle start with last output word 0x11 still in out_data.
        sv[0] = '{4'h1, 32'h000000A5, 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 8'h11};
        sv[1] = '{4'h0, 32'h000000A5, 1'b1, 4'b0000, 1'b1, 5'd1, 1'b0, 8'h11};
        sv[2] = '{4'h0, 32'h000000A5, 1'b1, 4'b0000, 1'b0, 5'd0, 1'b0, 8'h11};
        sv[3] = '{4'h0, 32'h000000A5, 1'b1, 4'b0000, 1'b0, 5'd0, 1'b1, 8'hA5};
        sv[4] = '{4'h0, 32'h000000A5, 1'b1, 4'b0000, 1'b0, 5'd0, 1'b0, 8'hA5};

        RSTn = 1'b0; req = 4'hF; req_data = 32'hDEADBEEF; out_ready = 1'b0;
        force_empty = 1'b0;
        #2;
        check_reset("rst0");
        @(posedge CLK); #1;
        RSTn = 1'b1;

        for (int i = 0; i < 7; i++) apply_vec(fv[i], $sformatf("fair%0d", i));
        out_ready = 1'b1; req = 4'h0;
        cyc(30);
        chk("fair_drained", sbq.size(), 0);
        chk("fair_nout", n_out, 6);
        chk("fair_level", level, 0);

        for (int i = 0; i < 5; i++) apply_vec(sv[i], $sformatf("single%0d", i));
        chk("single_nout", n_out, 7);

        // Full boundary: requester 2 streams with the consumer stalled.
        out_ready = 1'b0; req = 4'b0100; req_data = 32'h00400000; ngr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (level == 5'd16 && fifo_write) chk("full_write", fifo_write, 0);
            seen = gnt[2];
            if (seen) ngr++;
            @(posedge CLK); #1;
            if (seen) req_data = 32'(8'h40 + ngr) << 16;
        end
        @(negedge CLK);
        chk("full_grants", ngr, 17);
        chk("full_level", level, 16);
        chk("full_gnt", gnt, 0);
        chk("full_write_idle", fifo_write, 0);
        @(posedge CLK); #1;
        out_ready = 1'b1; t = 0; seen = 1'b0;
        while (!seen && t < 10) begin
            @(negedge CLK);
            if (gnt[2]) begin seen = 1'b1; chk("resume_level", level, 15); end
            @(posedge CLK); #1; t++;
            if (seen) req = 4'h0;
        end
        chk("resume_seen", seen, 1);
        req = 4'h0;
        cyc(60);
        chk("full_drained", sbq.size(), 0);
        chk("full_nout", n_out, 7 + 18);
        chk("full_level_end", level, 0);

        // Backpressure: five bytes, consumer ready toggling each cycle.
        out_ready = 1'b0;
        nbefore = n_out;
        for (int k = 1; k <= 5; k++) push(0, 8'(k));
        for (int c = 0; c < 40; c++) begin out_ready = ~out_ready; cyc(1); end
        out_ready = 1'b1;
        cyc(4);
        chk("bp_nout", n_out - nbefore, 5);
        chk("bp_drained", sbq.size(), 0);
        chk("bp_level", level, 0);

        // Reset mid-operation at level 7 with the output register full.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(1, 8'h80 + 8'(k));
        cyc(2);
        chk("pre_rst_level", level, 7);
        chk("pre_rst_ovalid", out_valid, 1);
        req = 4'b1000; req_data = 32'h5C000000;
        RSTn = 1'b0;
        #1;
        check_reset("rst_mid");
        sbq.delete();
        cyc(2);
        RSTn = 1'b1; out_ready = 1'b1;
        nbefore = n_out;
        @(negedge CLK);
        chk("post_rst_gnt", gnt, 4'b1000);
        @(posedge CLK); #1;
        req = 4'h0;
        cyc(8);
        chk("post_rst_nout", n_out - nbefore, 1);
        chk("post_rst_drained", sbq.size(), 0);
        chk("post_rst_odata", out_data, 8'h5C);

        // Consistency check: level 3 while the FIFO claims empty.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(2, 8'hC0 + 8'(k));
        cyc(3);
        chk("cons_level", level, 3);
        chk("cons_err_clean", err, 0);
        force_empty = 1'b1;
        @(negedge CLK);
        chk("cons_err_before_edge", err, 0);
        @(posedge CLK); #1;
        force_empty = 1'b0;
        @(negedge CLK);
        chk("cons_err_set", err, 1);
        cyc(3);
        chk("cons_err_sticky", err, 1);
        RSTn = 1'b0;
        #1;
        check_reset("rst_end");
        sbq.delete();
        cyc(1);
        RSTn = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sfifo_rr_ctrl.md
# sfifo_rr_ctrl

Round-robin write arbiter and read sequencer for the 16-deep × 8-bit synchronous FIFO (`iiitb_sfifo`). The block lets four producers share the FIFO write port. It also converts the FIFO's raw read strobe and registered read data into a valid/ready stream for one consumer. It keeps its own occupancy count and never drives a write into a full FIFO or a read from an empty one. It sits between the producers/consumer and the FIFO, and shares CLK/RSTn with it.

## Interface
- `NREQ`, 4: number of requesters (fixed; the arbiter is written for 4).
- `DEPTH`, 16: FIFO depth; must match the FIFO instance.
- `CLK` input 1: clock, rising edge.
- `RSTn` input 1: reset, asynchronous, active-low.
- `req` input 4: requester i has a byte to push; held until granted.
- `req_data` input 32: byte of requester i on bits [8i+7:8i].
- `gnt` output 4: one-hot; byte of requester i is accepted this cycle.
- `fifo_write` output 1: to FIFO `write`.
- `fifo_iData` output 8: to FIFO `iData`.
- `fifo_read` output 1: to FIFO `read`.
- `fifo_oData` input 8: from FIFO `oData` (registered; valid the cycle after `fifo_read`).
- `fifo_empty` input 1: from FIFO `empty`; used only for the consistency check.
- `out_valid` output 1: `out_data` holds a word.
- `out_data` output 8: output word.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `level` output 5: words in FIFO, 0..16.
- `err` output 1: sticky; set when `(level==0) != fifo_empty` with no read in flight.

## Operation
- **State registers:**
  - `level[4:0]`
  - `rr_ptr[1:0]`: last granted index.
  - `rd_pend`: read issued last cycle.
  - `out_valid`, `out_data[7:0]`
  - `err`
- **Write arbitration (combinational):**
  - If `level < 16`, grant the first asserted `req` searching from `rr_ptr+1` mod 4 upward.
  - `gnt` is one-hot; `fifo_write = |gnt`; `fifo_iData` = the granted requester's byte.
  - On a grant, `rr_ptr` ← granted index at the clock edge.
  - At `level == 16`: `gnt = 0`. This holds even if a read occurs the same cycle; there is no pass-through.
- **Read sequencing:**
  - `fifo_read = (level != 0) && !rd_pend && (!out_valid || out_ready)`.
  - Cycle after `fifo_read` (`rd_pend = 1`): `out_data` ← `fifo_oData`, `out_valid` ← 1.
  - Else if `out_valid && out_ready`: `out_valid` ← 0.
  - Peak output rate is 1 word per 2 cycles.
- **Level arithmetic:**
  - `level` ← `level + fifo_write − fifo_read`; write and read together leave it unchanged.
  - `level` never exceeds 16 and never underflows; both are guaranteed by the gating above.
- **Consistency check:** `err` sets when `!rd_pend && ((level==0) != fifo_empty)`. It clears only on reset.
- **Reset:**
  - Asynchronous, and clears FIFO pointers and controller state together.
  - While `RSTn = 0`, `gnt`, `fifo_write` and `fifo_read` are forced to 0.
  - A requester granted in the cycle reset asserts has lost its byte and must re-request.

## Timing
- **Reset values:**
  - `gnt = 0`, `fifo_write = 0`, `fifo_iData = 0`, `fifo_read = 0`
  - `out_valid = 0`, `out_data = 0x00`, `level = 0`, `err = 0`
  - `rr_ptr = 3`, so requester 0 has first priority.
- **Combinational outputs:** `gnt`, `fifo_write`, `fifo_iData` and `fifo_read` depend on `req`, `out_ready` and registered state. They are valid in the same cycle, with no registered delay.
- **Write acceptance:** a byte written at edge N is readable from edge N+1 (`level` ≥ 1 after edge N).
- **Write to output latency:** write at edge N → `fifo_read` high in cycle N+1 → `out_valid` high after edge N+2, given the output register is free.
- **Handshake rules:**
  - A producer must hold `req` and `req_data` stable until it sees `gnt`.
  - `out_data` is stable while `out_valid && !out_ready`.

## Test plan
- **Single producer:** `req = 0001`, data `0xA5`, one cycle, `out_ready = 1`.
  - `gnt = 0001` that cycle; `level` 0→1→0.
  - `out_valid = 1` with `0xA5` two cycles after the write, for one cycle.
- **Fairness:** `req = 1111` held, with data `0x10`/`0x11`/`0x12`/`0x13`, consumer stalled.
  - Grants go 0,1,2,3,0,… in consecutive cycles.
  - Drained output order is 10,11,12,13,10,…
- **Full boundary:** `out_ready = 0`, `req = 0100` held continuously.
  - Exactly 17 grants: 16 into the FIFO plus 1 held in the output register.
  - `gnt` then stays 0, `level = 16`, `fifo_write` never asserts.
  - Raising `out_ready` resumes grants once `level` drops to 15.
- **Backpressure:** fill with 1..5, then toggle `out_ready` every other cycle.
  - Output is 1,2,3,4,5 in order, with no duplicates or drops.
  - `out_data` is held while not ready; `level` ends at 0.
- **Reset mid-operation:** assert `RSTn = 0` at `level = 7`, `out_valid = 1`.
  - All outputs go to their reset values immediately.
  - After release, a single `req = 1000` receives the first grant and its byte is the next output.
- **Consistency check:** force `fifo_empty = 1` with `level = 3`. `err` rises next edge and stays high until reset.
